serial_subtractor: RTL and testbench

- Bit-serial multi-bit subtractor: computes Diff = A - B - Bin over WIDTH clock cycles, LSB first.
- Uses one half/full-subtractor bit cell plus a registered borrow flip-flop.
- Sits downstream of the combinational half/full subtractor cells and reuses their bit-level equations in sequence.
- Area-saving alternative to a ripple subtractor, with a start/done handshake toward the controlling logic.

---
 rtl/serial_subtractor.sv | 147 ++++++++++++++
 tb/tb_serial_subtractor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor: Diff = A - B - Bin (modulo 2^WIDTH), one bit per
// clock, LSB first. A single full-subtractor cell and a borrow flip-flop are
// reused for every bit position, which trades latency for area compared
// with a ripple subtractor.
//
// Ports
//   clk    in   1      system clock, rising-edge active
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      launch request, sampled only while idle
//   A      in   WIDTH  minuend, captured when start is accepted
//   B      in   WIDTH  subtrahend, captured when start is accepted
//   Bin    in   1      borrow-in, captured when start is accepted
//   busy   out  1      high while an operation is in flight (SHIFT, DONE)
//   done   out  1      single-cycle pulse, Diff/Borr just updated
//   Diff   out  WIDTH  registered difference, held until next completion
//   Borr   out  1      registered final borrow (1 when A < B + Bin)
//
// Timing: start accepted at edge 0, bits processed on edges 1..WIDTH, done
// is high during the cycle after edge WIDTH, back in IDLE after edge WIDTH+1.
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borr
);

  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_borr;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_borrow_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // Full-subtractor bit cell; returns {borrow_out, difference}.
  function automatic logic [1:0] fs_cell(input logic a, input logic b,
                                         input logic r);
    logic d;
    logic bo;
    d  = a ^ b ^ r;
    bo = (~a & b) | (~(a ^ b) & r);
    return {bo, d};
  endfunction

  always_comb begin
    {w_borrow_next, w_d} = fs_cell(r_opa[0], r_opb[0], r_borrow);
    // Right shift with the new bit entering at the MSB; written as shifts so
    // it also elaborates cleanly for WIDTH == 1.
    w_res_next = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
    w_last     = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_borr   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_opa    <= A;
            r_opb    <= B;
            r_borrow <= Bin;
            r_res    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SHIFT;
          end else begin
            r_busy <= 1'b0;
          end
        end

        S_SHIFT: begin
          r_opa    <= r_opa >> 1;
          r_opb    <= r_opb >> 1;
          r_borrow <= w_borrow_next;
          r_res    <= w_res_next;
          r_cnt    <= r_cnt + CW'(1);
          // Last bit: publish the completed result together with done.
          if (w_last) begin
            r_diff  <= w_res_next;
            r_borr  <= w_borrow_next;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          // start is deliberately not looked at here.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Diff = r_diff;
  assign Borr = r_borr;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor. Two instances share clock and reset:
// u_w8 (WIDTH=8) for the multi-bit cases and u_w1 (WIDTH=1) for the
// half-subtractor truth table. Outputs are sampled 1 time unit after the
// rising edge; inputs are driven at the same point.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       s8, bin8, busy8, done8, borr8;
  logic [7:0] a8, b8, diff8;

  logic       s1, bin1, busy1, done1, borr1;
  logic [0:0] a1, b1, diff1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .A(a8), .B(b8), .Bin(bin8),
    .busy(busy8), .done(done8), .Diff(diff8), .Borr(borr8)
  );

  serial_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .A(a1), .B(b1), .Bin(bin1),
    .busy(busy1), .done(done1), .Diff(diff1), .Borr(borr1)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation: checks result, done latency and busy duration.
  task automatic run8(input string tag, input logic [7:0] a,
                      input logic [7:0] b, input logic bi,
                      input logic [7:0] ed, input logic eb);
    int lat;
    int nbusy;
    bit seen;
    a8 = a; b8 = b; bin8 = bi; s8 = 1'b1;
    tick();
    s8 = 1'b0;
    lat   = 0;
    seen  = 1'b0;
    nbusy = busy8 ? 1 : 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick();
      if (busy8) nbusy++;
      if (done8) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check({tag, " latency"}, lat, 8);
    check({tag, " diff"}, diff8, ed);
    check({tag, " borr"}, borr8, eb);
    tick();
    if (busy8) nbusy++;
    check({tag, " busy_cycles"}, nbusy, 9);
    check({tag, " done_pulse_end"}, done8, 1'b0);
  endtask

  // One WIDTH=1 operation with Bin=0.
  task automatic run1(input string tag, input logic a, input logic b,
                      input logic ed, input logic eb);
    a1 = a; b1 = b; bin1 = 1'b0; s1 = 1'b1;
    tick();
    s1 = 1'b0;
    check({tag, " busy"}, busy1, 1'b1);
    tick();
    check({tag, " done"}, done1, 1'b1);
    check({tag, " diff"}, diff1, ed);
    check({tag, " borr"}, borr1, eb);
    tick();
    check({tag, " idle"}, {busy1, done1}, 2'b00);
  endtask

  initial begin
    int   ndone;
    int   first_at;
    int   second_at;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       bb2;
    logic       busy9;
    logic       busy10;
    bit         seen;

    rst_n = 1'b1;
    s8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    s1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  bin1 = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset w8 outputs", {busy8, done8, diff8, borr8}, 11'h000);
    check("reset w1 outputs", {busy1, done1, diff1, borr1}, 4'h0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("idle after reset", {busy8, done8}, 2'b00);

    // Arithmetic cases.
    run8("5A-3C",    8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    run8("00-01",    8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run8("FF-FF",    8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    run8("10-0F-1",  8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
    run8("00-00-1",  8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);

    // start during SHIFT and DONE is ignored.
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; s8 = 1'b1;
    tick();
    s8 = 1'b0;
    repeat (3) tick();
    check("diff held in shift", diff8, 8'hFF);
    a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1; s8 = 1'b1;
    tick();
    s8 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (done8) seen = 1'b1;
    end
    check("ignore done seen", seen, 1'b1);
    check("ignore diff", diff8, 8'h7F);
    check("ignore borr", borr8, 1'b0);
    a8 = 8'h11; b8 = 8'h22; s8 = 1'b1;
    tick();
    check("start in done ignored", busy8, 1'b0);
    s8 = 1'b0;
    tick();
    check("still idle", busy8, 1'b0);
    check("diff after ignore", diff8, 8'h7F);

    // Back-to-back with start held high.
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; s8 = 1'b1;
    tick();
    a8 = 8'h20; b8 = 8'h50;
    ndone = 0; first_at = 0; second_at = 0;
    d1 = 8'h00; d2 = 8'h00; bb2 = 1'b0; busy9 = 1'b1; busy10 = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (done8) begin
        ndone++;
        if (ndone == 1) begin
          first_at = k;
          d1 = diff8;
        end else begin
          second_at = k;
          d2  = diff8;
          bb2 = borr8;
          s8  = 1'b0;
        end
      end
      if (k == 9)  busy9  = busy8;
      if (k == 10) busy10 = busy8;
    end
    s8 = 1'b0;
    check("b2b done count", ndone, 2);
    check("b2b first at", first_at, 8);
    check("b2b second at", second_at, 18);
    check("b2b diff1", d1, 8'h22);
    check("b2b diff2", d2, 8'hD0);
    check("b2b borr2", bb2, 1'b1);
    check("b2b idle gap", busy9, 1'b0);
    check("b2b relaunch", busy10, 1'b1);
    tick();
    check("b2b idle end", busy8, 1'b0);

    // Reset in the middle of SHIFT, between clock edges.
    a8 = 8'hC3; b8 = 8'h42; bin8 = 1'b0; s8 = 1'b1;
    tick();
    s8 = 1'b0;
    repeat (4) tick();
    check("busy before abort", busy8, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort outputs", {busy8, done8, diff8, borr8}, 11'h000);
    tick();
    tick();
    check("abort no done", {busy8, done8}, 2'b00);
    #2 rst_n = 1'b1;
    tick();
    check("after abort idle", {busy8, done8}, 2'b00);
    run8("C3-42", 8'hC3, 8'h42, 1'b0, 8'h81, 1'b0);

    // WIDTH=1 half-subtractor truth table.
    run1("w1 0-0", 1'b0, 1'b0, 1'b0, 1'b0);
    run1("w1 0-1", 1'b0, 1'b1, 1'b1, 1'b1);
    run1("w1 1-0", 1'b1, 1'b0, 1'b1, 1'b0);
    run1("w1 1-1", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
